handshake_fifo: RTL

Elastic buffer that sits directly downstream of the `arf` dataflow fabric's `out` port and upstream of the bench consumer. It decouples the fabric's output operator from consumer stalls. Its upstream side acts as a receiver in the codebase's req/ack protocol and its downstream side acts as a sender. It stores up to `depth` words in order, so bursts of consumer `stop` cycles do not back-pressure the fabric.

---
 rtl/handshake_fifo_pkg.sv | 39 +++
 rtl/handshake_fifo_mem.sv | 41 ++++
 rtl/handshake_fifo.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/handshake_fifo_pkg.sv
// -----------------------------------------------------------------------------
// handshake_fifo_pkg
//
// Definitions shared by the blocks that talk the req/ack protocol: the
// handshake_fifo elastic buffer and the producer, consumer and async_operator
// blocks. Contents:
//   HS_DATA_WIDTH  default word width carried on every req/ack link
//   hs_xfer_t      per-edge transfer decision of one buffer (debug-friendly)
//   hs_send_ok()   the sender-side "may I acknowledge now" rule
//
// Handshake rule (identical on every link):
//   - The receiver holds req high while it can accept a word.
//   - The sender samples req at a rising edge. If req & ~ack at that edge it
//     drives ack high for exactly one cycle, registering the data on the same
//     edge; data is valid only while ack is high.
//   - Because the sender tests ~ack, ack can never be high on two consecutive
//     cycles, so a link moves at most one word every two cycles.
//   - A receiver that drops req must still take an ack the sender committed on
//     the edge where it saw req high, so receivers reserve that slot up front.
// -----------------------------------------------------------------------------
package handshake_fifo_pkg;

  // Default word width for every req/ack link in the fabric.
  localparam int HS_DATA_WIDTH = 32;

  // What one buffer does on a given clock edge.
  typedef struct packed {
    logic wr;    // upstream word is stored
    logic rd;    // a stored word is handed downstream
    logic drop;  // upstream word arrived with no free slot
  } hs_xfer_t;

  // Sender rule: acknowledge only when the receiver requests and no ack pulse
  // is already in flight.
  function automatic logic hs_send_ok(input logic req, input logic ack);
    return req & ~ack;
  endfunction

endpackage : handshake_fifo_pkg

// File: rtl/handshake_fifo_mem.sv
// -----------------------------------------------------------------------------
// handshake_fifo_mem (fifo_mem)
//
// depth x data_width storage array for handshake_fifo. One synchronous write
// port, one combinational read port. No reset: contents are meaningless until
// written, and the pointers in the top decide what is valid.
//
// Ports:
//   clk_i    clock
//   we_i     write enable, stores wdata_i at waddr_i on the rising edge
//   waddr_i  write address
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, combinational from raddr_i (pre-edge contents)
// -----------------------------------------------------------------------------
module handshake_fifo_mem #(
  parameter int data_width = 32,
  parameter int depth      = 4,
  parameter int aw         = 2
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [aw-1:0]         waddr_i,
  input  logic [data_width-1:0] wdata_i,
  input  logic [aw-1:0]         raddr_i,
  output logic [data_width-1:0] rdata_o
);

  logic [data_width-1:0] mem_q [depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read sees the contents before the current edge, so a word written on an
  // edge cannot be returned on that same edge.
  assign rdata_o = mem_q[raddr_i];

endmodule : handshake_fifo_mem

// File: rtl/handshake_fifo.sv
// -----------------------------------------------------------------------------
// handshake_fifo
//
// Elastic buffer between the arf fabric's out port and the bench consumer.
// Upstream it is a req/ack receiver, downstream a req/ack sender. It holds up
// to depth words in order so consumer stalls do not back-pressure the fabric.
//
// Parameters:
//   data_width  word width (default HS_DATA_WIDTH = 32)
//   depth       storage entries, power of two and >= 2
//   cw          occupancy width, derived; do not override
//
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset
//   req_l    out: "I can accept a word" to the upstream sender (registered)
//   ack_l    in : upstream one-cycle acknowledge, din valid while high
//   din      in : upstream data
//   req_r    in : downstream receiver request
//   ack_r    out: one-cycle acknowledge to downstream, dout valid while high
//   dout     out: downstream data (holds its last value between pulses)
//   count    out: occupancy 0..depth
//   err_ovf  out: sticky overflow flag, cleared only by reset
// -----------------------------------------------------------------------------
module handshake_fifo
  import handshake_fifo_pkg::*;
#(
  parameter int data_width = HS_DATA_WIDTH,
  parameter int depth      = 4,
  parameter int cw         = $clog2(depth + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  req_l,
  input  logic                  ack_l,
  input  logic [data_width-1:0] din,
  input  logic                  req_r,
  output logic                  ack_r,
  output logic [data_width-1:0] dout,
  output logic [cw-1:0]         count,
  output logic                  err_ovf
);

  // depth is a power of two, so pointers of this width wrap mod depth for free.
  localparam int            aw      = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [cw-1:0] depth_c = cw'(depth);

  logic [aw-1:0]         wr_ptr_q, wr_ptr_d;
  logic [aw-1:0]         rd_ptr_q, rd_ptr_d;
  logic [cw-1:0]         count_q, count_d;
  logic                  req_l_q, req_l_d;
  logic                  ack_r_q, ack_r_d;
  logic                  err_ovf_q, err_ovf_d;
  logic [data_width-1:0] dout_q, dout_d;
  logic [data_width-1:0] rd_data;
  logic                  full;
  hs_xfer_t              xfer;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  handshake_fifo_mem #(
    .data_width (data_width),
    .depth      (depth),
    .aw         (aw)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (xfer.wr),
    .waddr_i (wr_ptr_q),
    .wdata_i (din),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // ---------------------------------------------------------------------------
  // Per-edge transfer decision
  // ---------------------------------------------------------------------------
  always_comb begin
    full = (count_q == depth_c);

    // Downstream side behaves as a sender: only words already stored before
    // this edge are eligible, which rules out write-through.
    xfer.rd = hs_send_ok(req_r, ack_r_q) & (count_q != '0);

    // A read on the same edge frees the slot a full-buffer write needs.
    xfer.wr   = ack_l & (~full | xfer.rd);
    xfer.drop = ack_l & full & ~xfer.rd;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    dout_d    = dout_q;
    ack_r_d   = 1'b0;
    err_ovf_d = err_ovf_q | xfer.drop;

    if (xfer.wr) begin
      wr_ptr_d = wr_ptr_q + aw'(1);
    end

    if (xfer.rd) begin
      rd_ptr_d = rd_ptr_q + aw'(1);
      dout_d   = rd_data;
      ack_r_d  = 1'b1;
    end

    unique case ({xfer.wr, xfer.rd})
      2'b10:   count_d = count_q + cw'(1);
      2'b01:   count_d = count_q - cw'(1);
      default: count_d = count_q;
    endcase

    // Based on the post-edge occupancy: the sender may commit an ack on the
    // very edge it samples req_l high, and that word needs a guaranteed slot.
    req_l_d = (count_d < depth_c);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      req_l_q   <= 1'b0;
      ack_r_q   <= 1'b0;
      err_ovf_q <= 1'b0;
      dout_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      req_l_q   <= req_l_d;
      ack_r_q   <= ack_r_d;
      err_ovf_q <= err_ovf_d;
      dout_q    <= dout_d;
    end
  end

  assign req_l   = req_l_q;
  assign ack_r   = ack_r_q;
  assign dout    = dout_q;
  assign count   = count_q;
  assign err_ovf = err_ovf_q;

endmodule : handshake_fifo
